// File: rtl/reference_counter_averager_pkg.sv
// rtl/reference_counter_averager_pkg.sv - shared FSM encodings, defaults and window clamp helper
package reference_counter_averager_pkg;

    localparam int COUNTER_WIDTH_DEFAULT = 32;
    localparam int LOG2_DEPTH_DEFAULT    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_TRACK = 2'd2,
        ST_FLUSH = 2'd3
    } avg_state_e;

    // Requested window log2 limited to what the ring buffer can hold.
    function automatic logic [3:0] clamp_window(input logic [3:0] w, input logic [3:0] max_log2);
        return (w > max_log2) ? max_log2 : w;
    endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// rtl/sample_ring_buffer.sv - 1W/1R sample store with registered read, RAM-inferable
module sample_ring_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [WIDTH-1:0] rd_data_q;

    // Storage is deliberately never reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/reference_counter_averager.sv
// rtl/reference_counter_averager.sv - moving-average reference period with outlier rejection
module reference_counter_averager
    import reference_counter_averager_pkg::*;
#(
    parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT,
    parameter int LOG2_DEPTH    = LOG2_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic                     period_done,
    input  logic                     trigger_armed,
    input  logic [COUNTER_WIDTH-1:0] last_counter,
    input  logic [3:0]               window_log2,
    input  logic [COUNTER_WIDTH-1:0] tolerance,
    input  logic [7:0]               max_rejects,
    input  logic                     flush,
    output logic [COUNTER_WIDTH-1:0] reference_counter,
    output logic                     reference_valid,
    output logic [LOG2_DEPTH:0]      fill_level,
    output logic [15:0]              reject_count
);

    localparam int SUM_W = COUNTER_WIDTH + LOG2_DEPTH;

    avg_state_e               state_q, state_d;
    logic [3:0]               w_q, w_d;
    logic [SUM_W-1:0]         sum_q, sum_d;
    logic [LOG2_DEPTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic [LOG2_DEPTH:0]      fill_q, fill_d;
    logic [7:0]               run_q, run_d;
    logic [15:0]              rej_q, rej_d;
    logic [COUNTER_WIDTH-1:0] ref_q, ref_d;
    logic                     valid_q, valid_d;
    logic                     v0_q, v0_d, v1_q, v1_d;
    logic [COUNTER_WIDTH-1:0] s0_q, s0_d, s1_q, s1_d;

    logic [3:0]                    w_clamp;
    logic [LOG2_DEPTH:0]           win_size;
    logic [LOG2_DEPTH-1:0]         win_mask;
    logic                          running, flush_ext, take, c1_go, c2_go;
    logic                          outlier, resync, ram_we;
    logic [COUNTER_WIDTH-1:0]      old_data;
    logic signed [COUNTER_WIDTH:0] diff;
    logic [COUNTER_WIDTH:0]        abs_diff;

    assign w_clamp  = clamp_window(window_log2, 4'(LOG2_DEPTH));
    assign win_size = (LOG2_DEPTH+1)'(1) << w_q;
    assign win_mask = LOG2_DEPTH'(win_size - 1'b1);
    assign running  = (state_q == ST_FILL) || (state_q == ST_TRACK);

    // Freeze blocks everything, including flush requests; a pending window change fires on unfreeze.
    assign flush_ext = enable && running && !trigger_armed && (flush || (w_clamp != w_q));
    assign take      = enable && running && !trigger_armed && !flush_ext && period_done && !v0_q && !v1_q;
    assign c1_go     = enable && running && !trigger_armed && !flush_ext && v0_q;
    assign c2_go     = enable && running && !trigger_armed && !flush_ext && v1_q;

    assign diff     = $signed({1'b0, s0_q}) - $signed({1'b0, ref_q});
    assign abs_diff = diff[COUNTER_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    assign outlier  = (state_q == ST_TRACK) && (tolerance != '0) && (abs_diff > {1'b0, tolerance});
    assign ram_we   = aresetn && c1_go && !outlier;

    sample_ring_buffer #(
        .DEPTH_LOG2 (LOG2_DEPTH),
        .WIDTH      (COUNTER_WIDTH)
    ) u_buf (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_ptr_q),
        .wr_data (s0_q),
        .rd_en   (take),
        .rd_addr (wr_ptr_q),
        .rd_data (old_data)
    );

    // Next state: FSM, three-stage sample pipeline (c0 capture, c1 accumulate, c2 publish).
    always_comb begin
        state_d  = state_q;
        w_d      = w_q;
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        run_d    = run_q;
        rej_d    = rej_q;
        ref_d    = ref_q;
        valid_d  = valid_q;
        v0_d     = v0_q;
        s0_d     = s0_q;
        v1_d     = v1_q;
        s1_d     = s1_q;
        resync   = 1'b0;
        if (!enable) begin
            state_d  = ST_IDLE;
            w_d      = '0;
            sum_d    = '0;
            wr_ptr_d = '0;
            fill_d   = '0;
            run_d    = '0;
            rej_d    = '0;
            ref_d    = '0;
            valid_d  = 1'b0;
            v0_d     = 1'b0;
            s0_d     = '0;
            v1_d     = 1'b0;
            s1_d     = '0;
        end else begin
            if (state_q == ST_IDLE || state_q == ST_FLUSH) begin
                state_d = ST_FILL;
                w_d     = w_clamp;
            end
            if (take) begin
                v0_d = 1'b1;
                s0_d = last_counter;
            end
            if (c1_go) begin
                if (outlier) begin
                    rej_d = (rej_q == 16'hFFFF) ? rej_q : rej_q + 16'd1;
                    run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
                    // On resync the rejected sample stays in c0 and re-enters as the first FILL sample.
                    if (max_rejects != 8'd0 && run_d >= max_rejects) begin
                        resync = 1'b1;
                    end else begin
                        v0_d = 1'b0;
                    end
                end else begin
                    v0_d     = 1'b0;
                    v1_d     = 1'b1;
                    s1_d     = s0_q;
                    run_d    = '0;
                    sum_d    = sum_q + SUM_W'(s0_q)
                             - ((state_q == ST_TRACK) ? SUM_W'(old_data) : SUM_W'(0));
                    wr_ptr_d = (wr_ptr_q + 1'b1) & win_mask;
                    fill_d   = (fill_q == win_size) ? fill_q : fill_q + 1'b1;
                    if (state_q == ST_FILL && fill_d == win_size) begin
                        state_d = ST_TRACK;
                    end
                end
            end
            if (c2_go) begin
                v1_d    = 1'b0;
                ref_d   = (state_q == ST_FILL) ? s1_q : COUNTER_WIDTH'(sum_q >> w_q);
                valid_d = (state_q == ST_TRACK);
            end
            if (flush_ext || resync) begin
                state_d  = ST_FLUSH;
                sum_d    = '0;
                wr_ptr_d = '0;
                fill_d   = '0;
                run_d    = '0;
                valid_d  = 1'b0;
            end
            if (flush_ext) begin
                v0_d = 1'b0;
                v1_d = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            w_q      <= '0;
            sum_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            run_q    <= '0;
            rej_q    <= '0;
            ref_q    <= '0;
            valid_q  <= 1'b0;
            v0_q     <= 1'b0;
            s0_q     <= '0;
            v1_q     <= 1'b0;
            s1_q     <= '0;
        end else begin
            state_q  <= state_d;
            w_q      <= w_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            run_q    <= run_d;
            rej_q    <= rej_d;
            ref_q    <= ref_d;
            valid_q  <= valid_d;
            v0_q     <= v0_d;
            s0_q     <= s0_d;
            v1_q     <= v1_d;
            s1_q     <= s1_d;
        end
    end

    assign reference_counter = ref_q;
    assign reference_valid   = valid_q;
    assign fill_level        = fill_q;
    assign reject_count      = rej_q;

endmodule

// File: tb/tb_reference_counter_averager.sv
// tb/tb_reference_counter_averager.sv - self-checking bench for reference_counter_averager
module tb_reference_counter_averager;

    logic        clk = 1'b0;
    logic        aresetn, enable, period_done, trigger_armed, flush;
    logic [31:0] last_counter, tolerance;
    logic [3:0]  window_log2;
    logic [7:0]  max_rejects;
    logic [31:0] reference_counter;
    logic        reference_valid;
    logic [4:0]  fill_level;
    logic [15:0] reject_count;

    always #5 clk = ~clk;

    reference_counter_averager #(.COUNTER_WIDTH(32), .LOG2_DEPTH(4)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .enable            (enable),
        .period_done       (period_done),
        .trigger_armed     (trigger_armed),
        .last_counter      (last_counter),
        .window_log2       (window_log2),
        .tolerance         (tolerance),
        .max_rejects       (max_rejects),
        .flush             (flush),
        .reference_counter (reference_counter),
        .reference_valid   (reference_valid),
        .fill_level        (fill_level),
        .reject_count      (reject_count)
    );

    typedef struct {
        logic [3:0]  w;
        logic [31:0] tol;
        logic [7:0]  maxr;
        logic [31:0] smp;
        logic [31:0] e_ref;
        logic        e_valid;
        logic [4:0]  e_fill;
        logic [15:0] e_rej;
    } vec_t;

    vec_t vecs[19];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural reference: window contents as a queue, average by plain summation.
    logic [31:0] m_q[$];
    logic [31:0] m_ref;
    bit          m_track;
    int          m_rej, m_run, m_w;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] r, input logic v, input logic [4:0] f, input logic [15:0] j);
        chk({tag, ".ref"}, reference_counter, r);
        chk({tag, ".valid"}, 32'(reference_valid), 32'(v));
        chk({tag, ".fill"}, 32'(fill_level), 32'(f));
        chk({tag, ".rej"}, 32'(reject_count), 32'(j));
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input logic [31:0] s);
        period_done  = 1'b1;
        last_counter = s;
        @(negedge clk);
        period_done  = 1'b0;
    endtask

    task automatic send(input logic [31:0] s);
        strobe(s);
        tick(6);
    endtask

    function automatic int clampw(input int w);
        return (w > 4) ? 4 : w;
    endfunction

    task automatic m_flush();
        m_q.delete();
        m_track = 0;
        m_run   = 0;
    endtask

    task automatic m_accept(input logic [31:0] s);
        longint unsigned t;
        m_q.push_back(s);
        if (m_q.size() > (1 << m_w)) void'(m_q.pop_front());
        if (m_q.size() == (1 << m_w)) m_track = 1;
        if (m_track) begin
            t = 0;
            foreach (m_q[i]) t += longint'(m_q[i]);
            m_ref = 32'(t >> m_w);
        end else begin
            m_ref = s;
        end
    endtask

    task automatic m_sample(input logic [31:0] s);
        longint d;
        d = longint'(s) - longint'(m_ref);
        if (d < 0) d = -d;
        if (m_track && tolerance != 0 && d > longint'(tolerance)) begin
            if (m_rej < 65535) m_rej++;
            m_run++;
            if (max_rejects != 0 && m_run >= int'(max_rejects)) begin
                m_flush();
                m_accept(s);
            end
        end else begin
            m_run = 0;
            m_accept(s);
        end
    endtask

    initial begin
        vecs[0]  = '{4'd2, 32'd0, 8'd0, 32'd100, 32'd100, 1'b0, 5'd1, 16'd0};
        vecs[1]  = '{4'd2, 32'd0, 8'd0, 32'd102, 32'd102, 1'b0, 5'd2, 16'd0};
        vecs[2]  = '{4'd2, 32'd0, 8'd0, 32'd98,  32'd98,  1'b0, 5'd3, 16'd0};
        vecs[3]  = '{4'd2, 32'd0, 8'd0, 32'd100, 32'd100, 1'b1, 5'd4, 16'd0};
        vecs[4]  = '{4'd2, 32'd0, 8'd0, 32'd104, 32'd101, 1'b1, 5'd4, 16'd0};
        vecs[5]  = '{4'd2, 32'd5, 8'd3, 32'd100, 32'd100, 1'b1, 5'd4, 16'd0};
        vecs[6]  = '{4'd2, 32'd5, 8'd3, 32'd200, 32'd100, 1'b1, 5'd4, 16'd1};
        vecs[7]  = '{4'd2, 32'd5, 8'd3, 32'd200, 32'd100, 1'b1, 5'd4, 16'd2};
        vecs[8]  = '{4'd2, 32'd5, 8'd3, 32'd200, 32'd200, 1'b0, 5'd1, 16'd3};
        vecs[9]  = '{4'd2, 32'd5, 8'd3, 32'd10,  32'd10,  1'b0, 5'd2, 16'd3};
        vecs[10] = '{4'd2, 32'd5, 8'd3, 32'd20,  32'd20,  1'b0, 5'd3, 16'd3};
        vecs[11] = '{4'd2, 32'd5, 8'd3, 32'd30,  32'd65,  1'b1, 5'd4, 16'd3};
        vecs[12] = '{4'd1, 32'd0, 8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5'd1, 16'd3};
        vecs[13] = '{4'd1, 32'd0, 8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5'd2, 16'd3};
        vecs[14] = '{4'd1, 32'd0, 8'd0, 32'd1, 32'h80000000, 1'b1, 5'd2, 16'd3};
        vecs[15] = '{4'd0, 32'd0, 8'd0, 32'd7, 32'd7, 1'b1, 5'd1, 16'd3};
        vecs[16] = '{4'd0, 32'd0, 8'd0, 32'h12345678, 32'h12345678, 1'b1, 5'd1, 16'd3};
        vecs[17] = '{4'd5, 32'd0, 8'd0, 32'd16, 32'd16, 1'b0, 5'd1, 16'd3};
        vecs[18] = '{4'd4, 32'd0, 8'd0, 32'd32, 32'd32, 1'b0, 5'd2, 16'd3};

        aresetn = 1'b0; enable = 1'b0; period_done = 1'b0; trigger_armed = 1'b0; flush = 1'b0;
        last_counter = '0; tolerance = '0; window_log2 = 4'd2; max_rejects = '0;
        tick(3);
        chk_all("reset", 32'd0, 1'b0, 5'd0, 16'd0);
        aresetn = 1'b1;
        enable  = 1'b1;
        tick(3);
        chk_all("idle_en", 32'd0, 1'b0, 5'd0, 16'd0);

        // Table-driven directed scenarios.
        for (int i = 0; i < 19; i++) begin
            if (window_log2 != vecs[i].w) begin
                window_log2 = vecs[i].w;
                tick(3);
            end
            tolerance   = vecs[i].tol;
            max_rejects = vecs[i].maxr;
            send(vecs[i].smp);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ref, vecs[i].e_valid, vecs[i].e_fill, vecs[i].e_rej);
        end

        // Freeze: strobes and window changes ignored until unfrozen.
        trigger_armed = 1'b1;
        send(32'd500);
        send(32'd500);
        chk_all("freeze", 32'd32, 1'b0, 5'd2, 16'd3);
        window_log2 = 4'd3;
        tick(3);
        chk("freeze_wchg.fill", 32'(fill_level), 32'd2);
        trigger_armed = 1'b0;
        tick(1);
        chk("unfreeze_flush.fill", 32'(fill_level), 32'd0);
        tick(2);

        // Latency: strobe edge T, reference updates at edge T+2.
        strobe(32'd77);
        tick(1);
        chk("lat_early.ref", reference_counter, 32'd32);
        tick(1);
        chk("lat_ontime.ref", reference_counter, 32'd77);
        chk("lat_ontime.fill", 32'(fill_level), 32'd1);
        tick(3);

        // Back-to-back strobes: second is dropped while busy.
        period_done = 1'b1; last_counter = 32'd88;
        tick(1);
        last_counter = 32'd99;
        tick(1);
        period_done = 1'b0;
        tick(5);
        chk("busy.ref", reference_counter, 32'd88);
        chk("busy.fill", 32'(fill_level), 32'd2);

        // Flush coinciding with a strobe: strobe dropped.
        period_done = 1'b1; flush = 1'b1; last_counter = 32'd111;
        tick(1);
        period_done = 1'b0; flush = 1'b0;
        chk("flush.fill", 32'(fill_level), 32'd0);
        tick(7);
        chk("flush_drop.fill", 32'(fill_level), 32'd0);
        chk("flush_drop.ref", reference_counter, 32'd88);

        // Reset one cycle after a strobe: no late update.
        strobe(32'd123);
        aresetn = 1'b0;
        tick(1);
        chk_all("rst_mid", 32'd0, 1'b0, 5'd0, 16'd0);
        aresetn = 1'b1;
        tick(5);
        chk_all("rst_late", 32'd0, 1'b0, 5'd0, 16'd0);

        // Disable one cycle after a strobe.
        send(32'd55);
        chk("pre_dis.ref", reference_counter, 32'd55);
        strobe(32'd66);
        enable = 1'b0;
        tick(1);
        chk_all("dis_mid", 32'd0, 1'b0, 5'd0, 16'd0);
        tick(4);
        enable = 1'b1;
        tick(5);
        chk_all("dis_late", 32'd0, 1'b0, 5'd0, 16'd0);

        // Randomized run against the queue model.
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        window_log2 = 4'd2; tolerance = 32'd0; max_rejects = 8'd0;
        m_w = 2; m_ref = '0; m_rej = 0; m_flush();
        tick(3);
        for (int it = 0; it < 400; it++) begin
            logic [31:0] s;
            if (it % 25 == 0) begin
                int nw;
                nw = int'($urandom_range(0, 6));
                if (clampw(nw) != m_w) begin
                    m_flush();
                    m_w = clampw(nw);
                end
                window_log2 = 4'(nw);
                case ($urandom_range(0, 2))
                    0: tolerance = 32'd0;
                    1: tolerance = 32'd20;
                    default: tolerance = 32'd60;
                endcase
                max_rejects = 8'($urandom_range(0, 3));
                tick(3);
            end
            if ($urandom_range(0, 39) == 0) begin
                flush = 1'b1;
                tick(1);
                flush = 1'b0;
                m_flush();
                tick(2);
            end
            if ($urandom_range(0, 5) == 0) s = 32'd5000 + 32'($urandom_range(0, 3000));
            else s = 32'd1000 + 32'($urandom_range(0, 100));
            send(s);
            m_sample(s);
            chk_all($sformatf("rnd%0d", it), m_ref, m_track, 5'(m_q.size()), 16'(m_rej));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
